// File: rtl/ascii_pkg.sv
// ASCII character constants and classification helpers shared by case-conversion paths.
// Latency: n/a (constants and a combinational function only).
// Backpressure: n/a.
package ascii_pkg;

  localparam logic [7:0] ASCII_UPPER_A = 8'h41;
  localparam logic [7:0] ASCII_UPPER_Z = 8'h5A;
  localparam logic [7:0] ASCII_NUL     = 8'h00;
  localparam int         CASE_BIT      = 5;

  // True for 'A'..'Z' only; bytes with bit 7 set fall outside the range naturally.
  function automatic logic is_upper(input logic [7:0] b);
    return (b >= ASCII_UPPER_A) && (b <= ASCII_UPPER_Z);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered storage; full/empty derived from wrap-bit pointers.
// Latency: a write is visible at rdata the cycle after the push edge.
// Backpressure: push ignored while full, pop ignored while empty; no full-with-pop pass-through.
//
// Ports: clk, rst_n (sync, active-low), push/wdata write side, pop read side,
//        full/empty status, rdata = head entry (forced to 0 while empty).
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] rdata
);

  localparam int AW = $clog2(DEPTH);

  // One extra pointer bit separates "wrapped, same slot" (full) from "same slot" (empty).
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q[AW-1:0]] = wdata;
      wr_ptr_d                = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: rdata is masked while empty.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/to_lower_stream.sv
// Streaming ASCII lowercase converter with output FIFO, saturating conversion counter and per-string stats.
// Latency: byte accepted at edge N appears on out_data at N+1 when the FIFO was empty; counters update at N+1.
// Backpressure: in_ready = FIFO not full (and out of reset); out_ready has no combinational path to in_ready.
//
// Ports: clk, rst_n (sync, active-low); in_data/in_valid/in_ready byte input; out_data/out_valid/out_ready
//        converted byte output; clr_cnt clears conv_cnt; conv_cnt running total; str_done/str_conv per-NUL stats.
module to_lower_stream
  import ascii_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [7:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] conv_cnt,
  output logic             str_done,
  output logic [CNT_W-1:0] str_conv
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic             fifo_full;
  logic             fifo_empty;
  logic             accept;
  logic             conv_hit;
  logic             nul_hit;
  logic [7:0]       wr_byte;

  logic [CNT_W-1:0] conv_cnt_q, conv_cnt_d;
  logic [CNT_W-1:0] str_acc_q,  str_acc_d;
  logic [CNT_W-1:0] str_conv_q, str_conv_d;
  logic             str_done_q, str_done_d;

  assign in_ready  = !fifo_full && rst_n;
  assign out_valid = !fifo_empty;
  assign accept    = in_valid && in_ready;
  assign conv_hit  = accept && is_upper(in_data);
  assign nul_hit   = accept && (in_data == ASCII_NUL);

  always_comb begin
    wr_byte = in_data;
    if (is_upper(in_data)) begin
      wr_byte[CASE_BIT] = 1'b1;
    end
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (accept),
    .wdata (wr_byte),
    .pop   (out_ready),
    .full  (fifo_full),
    .empty (fifo_empty),
    .rdata (out_data)
  );

  always_comb begin
    conv_cnt_d = conv_cnt_q;
    str_acc_d  = str_acc_q;
    str_conv_d = str_conv_q;
    str_done_d = nul_hit;

    // Clear wins over a same-cycle conversion.
    if (clr_cnt) begin
      conv_cnt_d = '0;
    end else if (conv_hit && (conv_cnt_q != CNT_MAX)) begin
      conv_cnt_d = conv_cnt_q + 1'b1;
    end

    // NUL is never uppercase, so closing a string and counting are mutually exclusive.
    if (nul_hit) begin
      str_conv_d = str_acc_q;
      str_acc_d  = '0;
    end else if (conv_hit && (str_acc_q != CNT_MAX)) begin
      str_acc_d = str_acc_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      conv_cnt_q <= '0;
      str_acc_q  <= '0;
      str_conv_q <= '0;
      str_done_q <= 1'b0;
    end else begin
      conv_cnt_q <= conv_cnt_d;
      str_acc_q  <= str_acc_d;
      str_conv_q <= str_conv_d;
      str_done_q <= str_done_d;
    end
  end

  assign conv_cnt = conv_cnt_q;
  assign str_conv = str_conv_q;
  assign str_done = str_done_q;

endmodule
